// File: rtl/neuron_train_sched.sv
// Training scheduler: replays a small sample buffer into one neuron_learn instance
// epoch by epoch, accumulating |expected - out| and stopping on threshold or epoch limit.
module neuron_train_sched #(
    parameter int N           = 16,
    parameter int DEPTH       = 8,
    parameter int INIT_CYCLES = 4,
    parameter int ERR_W       = 16,
    localparam int Z_W        = 8,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [N*Z_W-1:0]   load_in,
    input  logic [Z_W-1:0]     load_expected,
    output logic [CNT_W-1:0]   sample_count,
    input  logic               start,
    input  logic [15:0]        max_epochs,
    input  logic [ERR_W-1:0]   err_threshold,
    output logic               busy,
    output logic               done,
    output logic [15:0]        epoch_count,
    output logic [ERR_W-1:0]   epoch_error,
    output logic               nrn_valid,
    output logic               nrn_learn,
    output logic [N*Z_W-1:0]   nrn_in,
    output logic [Z_W-1:0]     nrn_expected_out,
    input  logic [Z_W-1:0]     nrn_out
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int SUM_W  = ((ERR_W > Z_W) ? ERR_W : Z_W) + 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [SUM_W-1:0]  ERR_MAX   = SUM_W'({ERR_W{1'b1}});

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_PRESENT, S_UPDATE, S_EPOCH_END, S_DONE
    } state_t;

    // zero2one_t is an 8-bit unsigned fraction; differences need one extra sign bit.
    function automatic logic signed [Z_W:0] zero2one_sub_signed(
        input logic [Z_W-1:0] a, input logic [Z_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic logic [Z_W-1:0] zero2one_signed_abs_zero2one(
        input logic signed [Z_W:0] v);
        logic [Z_W:0] mag;
        mag = (v < 0) ? $unsigned(-v) : $unsigned(v);
        return mag[Z_W] ? {Z_W{1'b1}} : mag[Z_W-1:0];
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [INIT_W-1:0]  init_q, init_d;
    logic [ERR_W-1:0]   acc_q, acc_d;
    logic [ERR_W-1:0]   ep_err_q, ep_err_d;
    logic [15:0]        ep_cnt_q, ep_cnt_d;
    logic [15:0]        max_ep_q, max_ep_d;
    logic [ERR_W-1:0]   thr_q, thr_d;
    logic [N*Z_W-1:0]   nin_q, nin_d;
    logic [Z_W-1:0]     nexp_q, nexp_d;

    logic [N*Z_W-1:0]   buf_in_q  [DEPTH];
    logic [Z_W-1:0]     buf_exp_q [DEPTH];

    logic               wr_en;
    logic               fetch;
    logic [IDX_W-1:0]   rd_idx;
    logic [Z_W-1:0]     abs_err;
    logic [SUM_W-1:0]   sum;

    assign load_ready       = (state_q == S_IDLE) && (cnt_q < CNT_W'(DEPTH));
    assign sample_count     = cnt_q;
    assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done             = (state_q == S_DONE);
    assign epoch_count      = ep_cnt_q;
    assign epoch_error      = ep_err_q;
    assign nrn_valid        = (state_q != S_INIT);
    assign nrn_learn        = (state_q == S_UPDATE);
    assign nrn_in           = nin_q;
    assign nrn_expected_out = nexp_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        init_d   = init_q;
        acc_d    = acc_q;
        ep_err_d = ep_err_q;
        ep_cnt_d = ep_cnt_q;
        max_ep_d = max_ep_q;
        thr_d    = thr_q;
        nin_d    = nin_q;
        nexp_d   = nexp_q;
        wr_en    = 1'b0;
        fetch    = 1'b0;
        rd_idx   = '0;
        abs_err  = '0;
        sum      = '0;

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    cnt_d = '0;
                end else begin
                    if (load_valid && load_ready) begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (start && (cnt_q != '0)) begin
                        max_ep_d = (max_epochs == 16'd0) ? 16'd1 : max_epochs;
                        thr_d    = err_threshold;
                        ep_cnt_d = '0;
                        idx_d    = '0;
                        acc_d    = '0;
                        init_d   = '0;
                        state_d  = S_INIT;
                    end
                end
            end
            S_INIT: begin
                if (init_q == INIT_LAST) begin
                    state_d = S_PRESENT;
                    idx_d   = '0;
                    fetch   = 1'b1;
                end else begin
                    init_d = init_q + INIT_W'(1);
                end
            end
            S_PRESENT: begin
                abs_err = zero2one_signed_abs_zero2one(zero2one_sub_signed(nexp_q, nrn_out));
                sum     = SUM_W'(acc_q) + SUM_W'(abs_err);
                acc_d   = (sum > ERR_MAX) ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if ((CNT_W'(idx_q) + CNT_W'(1)) < cnt_q) begin
                    idx_d   = idx_q + IDX_W'(1);
                    rd_idx  = idx_q + IDX_W'(1);
                    fetch   = 1'b1;
                    state_d = S_PRESENT;
                end else begin
                    state_d = S_EPOCH_END;
                end
            end
            S_EPOCH_END: begin
                ep_err_d = acc_q;
                ep_cnt_d = (ep_cnt_q == 16'hFFFF) ? 16'hFFFF : ep_cnt_q + 16'd1;
                acc_d    = '0;
                if ((acc_q <= thr_q) || (({1'b0, ep_cnt_q} + 17'd1) == {1'b0, max_ep_q})) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = '0;
                    fetch   = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Neuron drive registers change only on entry to PRESENT, so they stay put through UPDATE.
        if (fetch) begin
            nin_d  = buf_in_q[rd_idx];
            nexp_d = buf_exp_q[rd_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            init_q   <= '0;
            acc_q    <= '0;
            ep_err_q <= '0;
            ep_cnt_q <= '0;
            max_ep_q <= 16'd1;
            thr_q    <= '0;
            nin_q    <= '0;
            nexp_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            init_q   <= init_d;
            acc_q    <= acc_d;
            ep_err_q <= ep_err_d;
            ep_cnt_q <= ep_cnt_d;
            max_ep_q <= max_ep_d;
            thr_q    <= thr_d;
            nin_q    <= nin_d;
            nexp_q   <= nexp_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            buf_in_q[cnt_q[IDX_W-1:0]]  <= load_in;
            buf_exp_q[cnt_q[IDX_W-1:0]] <= load_expected;
        end
    end

endmodule

// File: tb/tb_neuron_train_sched.sv
// Bench for neuron_train_sched: two instances (wide and 4-bit error accumulator) share stimulus;
// presentation order and run results are checked against a scoreboard.
module tb_neuron_train_sched;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int INITC = 4;

    typedef struct packed {
        logic [N*8-1:0] vin;
        logic [7:0]     vexp;
    } sample_t;

    typedef struct {
        int ep;
        int err_a;
        int err_b;
        int cyc;
    } result_t;

    logic           clock = 1'b0;
    logic           reset, clear, load_valid, start;
    logic [N*8-1:0] load_in;
    logic [7:0]     load_expected;
    logic [15:0]    max_epochs;
    logic [15:0]    err_threshold;
    logic [7:0]     delta;

    logic           load_ready_a, busy_a, done_a, nrn_valid_a, nrn_learn_a;
    logic [2:0]     sample_count_a;
    logic [15:0]    epoch_count_a, epoch_error_a;
    logic [N*8-1:0] nrn_in_a;
    logic [7:0]     nrn_expected_out_a, nrn_out_a;

    logic           load_ready_b, busy_b, done_b, nrn_valid_b, nrn_learn_b;
    logic [2:0]     sample_count_b;
    logic [15:0]    epoch_count_b;
    logic [3:0]     epoch_error_b;
    logic [N*8-1:0] nrn_in_b;
    logic [7:0]     nrn_expected_out_b, nrn_out_b;

    int n_cmp = 0;
    int n_bad = 0;

    sample_t model_buf[$];
    sample_t pres_q[$];
    result_t res_q[$];

    always #5 clock = ~clock;

    // Neuron stand-in: output is the expected value offset by delta LSBs.
    assign nrn_out_a = nrn_expected_out_a + delta;
    assign nrn_out_b = nrn_expected_out_b + delta;

    neuron_train_sched #(.N(N), .DEPTH(DEPTH), .INIT_CYCLES(INITC), .ERR_W(16)) dut_a (
        .clock(clock), .reset(reset), .clear(clear),
        .load_valid(load_valid), .load_ready(load_ready_a),
        .load_in(load_in), .load_expected(load_expected),
        .sample_count(sample_count_a), .start(start),
        .max_epochs(max_epochs), .err_threshold(err_threshold),
        .busy(busy_a), .done(done_a), .epoch_count(epoch_count_a), .epoch_error(epoch_error_a),
        .nrn_valid(nrn_valid_a), .nrn_learn(nrn_learn_a), .nrn_in(nrn_in_a),
        .nrn_expected_out(nrn_expected_out_a), .nrn_out(nrn_out_a)
    );

    neuron_train_sched #(.N(N), .DEPTH(DEPTH), .INIT_CYCLES(INITC), .ERR_W(4)) dut_b (
        .clock(clock), .reset(reset), .clear(clear),
        .load_valid(load_valid), .load_ready(load_ready_b),
        .load_in(load_in), .load_expected(load_expected),
        .sample_count(sample_count_b), .start(start),
        .max_epochs(max_epochs), .err_threshold(err_threshold[3:0]),
        .busy(busy_b), .done(done_b), .epoch_count(epoch_count_b), .epoch_error(epoch_error_b),
        .nrn_valid(nrn_valid_b), .nrn_learn(nrn_learn_b), .nrn_in(nrn_in_b),
        .nrn_expected_out(nrn_expected_out_b), .nrn_out(nrn_out_b)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic sample_t randSample();
        sample_t s;
        s.vin  = N*8'($urandom);
        s.vexp = 8'($urandom_range(0, 200));
        return s;
    endfunction

    // Drives one sample for the coming edge; back-to-back calls keep load_valid high.
    task automatic applyStimulus(input sample_t s, input bit accept);
        @(negedge clock);
        checkOutput("load_ready", {63'd0, load_ready_a}, {63'd0, accept});
        load_valid    = 1'b1;
        load_in       = s.vin;
        load_expected = s.vexp;
        if (accept) model_buf.push_back(s);
    endtask

    task automatic endLoad();
        @(negedge clock);
        load_valid = 1'b0;
    endtask

    task automatic doClear();
        @(negedge clock);
        clear         = 1'b1;
        load_valid    = 1'b1;
        load_in       = '1;
        load_expected = 8'h55;
        @(negedge clock);
        clear      = 1'b0;
        load_valid = 1'b0;
        checkOutput("clear_count", 64'(sample_count_a), 64'd0);
        model_buf.delete();
    endtask

    task automatic runTraining(input int max_ep, input int thr, input int d,
                               input int exp_ep, input int exp_err, input int exp_cyc);
        result_t r;
        result_t got;
        sample_t p;
        int cyc = 0;
        int init_low = 0;
        int viol = 0;
        bit seen = 0;
        r.ep    = exp_ep;
        r.err_a = exp_err;
        r.err_b = (exp_err > 15) ? 15 : exp_err;
        r.cyc   = exp_cyc;
        res_q.push_back(r);
        for (int e = 0; e < exp_ep; e++)
            foreach (model_buf[i]) pres_q.push_back(model_buf[i]);
        @(negedge clock);
        delta         = 8'(d);
        max_epochs    = 16'(max_ep);
        err_threshold = 16'(thr);
        start         = 1'b1;
        while (cyc < 400 && !seen) begin
            @(negedge clock);
            start = 1'b0;
            cyc++;
            if (!nrn_valid_a) init_low++;
            if (nrn_learn_a && !nrn_valid_a) viol++;
            if (nrn_learn_a) begin
                if (pres_q.size() == 0) begin
                    checkOutput("extra_presentation", 64'd1, 64'd0);
                end else begin
                    p = pres_q.pop_front();
                    checkOutput("nrn_in", 64'(nrn_in_a), 64'(p.vin));
                    checkOutput("nrn_expected_out", 64'(nrn_expected_out_a), 64'(p.vexp));
                end
            end
            if (done_a) seen = 1;
        end
        checkOutput("done_seen", {63'd0, seen}, 64'd1);
        got = res_q.pop_front();
        checkOutput("run_cycles", 64'(cyc), 64'(got.cyc));
        checkOutput("init_low_cycles", 64'(init_low), 64'(INITC));
        checkOutput("learn_without_valid", 64'(viol), 64'd0);
        checkOutput("epoch_count", 64'(epoch_count_a), 64'(got.ep));
        checkOutput("epoch_error_a", 64'(epoch_error_a), 64'(got.err_a));
        checkOutput("epoch_error_b", 64'(epoch_error_b), 64'(got.err_b));
        checkOutput("done_b_aligned", {63'd0, done_b}, 64'd1);
        checkOutput("presentations_left", 64'(pres_q.size()), 64'd0);
        pres_q.delete();
        @(negedge clock);
        checkOutput("done_one_cycle", {63'd0, done_a}, 64'd0);
        checkOutput("busy_after_done", {63'd0, busy_a}, 64'd0);
    endtask

    initial begin
        bit any_busy;
        int wait_cyc;
        reset = 1'b1; clear = 1'b0; load_valid = 1'b0; start = 1'b0;
        load_in = '0; load_expected = '0; max_epochs = 16'd1; err_threshold = '0; delta = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_busy", {63'd0, busy_a}, 64'd0);
        checkOutput("rst_done", {63'd0, done_a}, 64'd0);
        checkOutput("rst_valid", {63'd0, nrn_valid_a}, 64'd1);
        checkOutput("rst_learn", {63'd0, nrn_learn_a}, 64'd0);
        checkOutput("rst_count", 64'(sample_count_a), 64'd0);
        checkOutput("rst_epoch_count", 64'(epoch_count_a), 64'd0);
        checkOutput("rst_epoch_error", 64'(epoch_error_a), 64'd0);
        checkOutput("rst_nrn_in", 64'(nrn_in_a), 64'd0);
        checkOutput("rst_nrn_exp", 64'(nrn_expected_out_a), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] empty start");
        start = 1'b1;
        any_busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (busy_a || done_a) any_busy = 1;
        end
        checkOutput("empty_start_ignored", {63'd0, any_busy}, 64'd0);

        $display("[TB] load until full");
        for (int i = 0; i < 5; i++) applyStimulus(randSample(), i < DEPTH);
        endLoad();
        checkOutput("full_count", 64'(sample_count_a), 64'd4);
        runTraining(1, 0, 0, 1, 0, INITC + 1 + 2*4 + 1);
        doClear();

        $display("[TB] sequencing");
        for (int i = 0; i < 3; i++) applyStimulus(randSample(), 1);
        endLoad();
        checkOutput("seq_count", 64'(sample_count_a), 64'd3);
        runTraining(2, 0, 1, 2, 3, INITC + 1 + 2*7);

        $display("[TB] early stop");
        runTraining(10, 0, 0, 1, 0, INITC + 1 + 7);

        $display("[TB] saturation");
        doClear();
        for (int i = 0; i < 4; i++) applyStimulus(randSample(), 1);
        endLoad();
        runTraining(1, 0, 5, 1, 20, INITC + 1 + 9);

        $display("[TB] max_epochs zero");
        runTraining(0, 0, 1, 1, 4, INITC + 1 + 9);

        $display("[TB] reset mid-run");
        @(negedge clock);
        delta = 8'd1; max_epochs = 16'd3; err_threshold = '0; start = 1'b1;
        wait_cyc = 0;
        do begin
            @(negedge clock);
            start = 1'b0;
            wait_cyc++;
        end while (!nrn_learn_a && wait_cyc < 100);
        checkOutput("reached_update", {63'd0, nrn_learn_a}, 64'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("mid_rst_busy", {63'd0, busy_a}, 64'd0);
        checkOutput("mid_rst_learn", {63'd0, nrn_learn_a}, 64'd0);
        checkOutput("mid_rst_valid", {63'd0, nrn_valid_a}, 64'd1);
        checkOutput("mid_rst_count", 64'(sample_count_a), 64'd0);
        checkOutput("mid_rst_epoch_count", 64'(epoch_count_a), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        any_busy = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (done_a || busy_a) any_busy = 1;
        end
        checkOutput("no_done_after_reset", {63'd0, any_busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
